// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_controller_pkg;

  // FSM states; encodings are visible on the debug state output.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StError    = 4'd11
  } state_e;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // ALUOp codes from the FSM to the ALU decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALUControl codes
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // ImmSrc codes
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;

  // Datapath mux selects
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARegA  = 2'b10;

  localparam logic [1:0] SrcBWriteData = 2'b00;
  localparam logic [1:0] SrcBImm       = 2'b01;
  localparam logic [1:0] SrcBFour      = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function bits to an ALUControl code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_control_o
);

  // Decode ALU operation; sub only for R-type with funct7b5 (addi ignores it).
  always_comb begin
    alu_control_o = AluAdd;
    case (alu_op_i)
      AluOpAdd: alu_control_o = AluAdd;
      AluOpSub: alu_control_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluAdd;
        endcase
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle RV32I core (Moore FSM + ALU/immediate decode).
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky ERROR state;
// otherwise unknown opcodes behave as a NOP and illegal stays 0.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;

  // State register, asynchronously cleared to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; enables are masked while reset is held low.
  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBWriteData;
    alu_op    = AluOpAdd;
    illegal   = 1'b0;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluRes;
        PCWrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
`ifdef ILLEGAL_TRAP_EN
          default:         state_d = StError;
`else
          // PC already advanced in FETCH, so skipping is a NOP.
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARegA;
        ALUSrcB = SrcBImm;
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = StFetch;
      end
      StExecR: begin
        ALUSrcA = SrcARegA;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARegA;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBeq: begin
        ALUSrcA = SrcARegA;
        alu_op  = AluOpSub;
        // Only Mealy output: take the branch target held in ALUOut.
        PCWrite = zero;
        state_d = StFetch;
      end
      StJal: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBFour;
        PCWrite = 1'b1;
        state_d = StAluWb;
      end
      StError: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = StError;
`else
        state_d = StFetch;
`endif
      end
      default: state_d = StFetch;
    endcase
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  // Immediate format from the opcode, valid every cycle.
  always_comb begin
    case (op)
      OpStore:  ImmSrc = ImmS;
      OpBranch: ImmSrc = ImmB;
      OpJal:    ImmSrc = ImmJ;
      default:  ImmSrc = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op5_i        (op[5]),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .alu_op_i     (alu_op),
    .alu_control_o(ALUControl)
  );

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with a per-instruction reference model.
// Honours ILLEGAL_TRAP_EN when defined for the build.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  logic [21:0] obs;
  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];

  multicycle_controller #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, SrcA, SrcB, ALUCtl, Imm, ill}
  assign obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, illegal};

  function automatic logic [21:0] vec(int st, bit pcw, bit adr, bit mw, bit irw, bit rw,
                                      int rs, int sa, int sb, int ac, int imm, bit ill);
    return {st[3:0], pcw, adr, mw, irw, rw, rs[1:0], sa[1:0], sb[1:0], ac[2:0], imm[2:0], ill};
  endfunction

  function automatic int imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 1;
    if (o == 7'b1100011) return 2;
    if (o == 7'b1101111) return 3;
    return 0;
  endfunction

  function automatic bit is_legal(logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  // ALU operation expected for an R/I arithmetic instruction.
  function automatic int arith_ctl(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  // Expected cycle-by-cycle control vectors for one instruction, FETCH onward.
  task automatic model_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    int im;
    im = imm_of(o);
    exp_q.delete();
    exp_q.push_back(vec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, im, 0));
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, im, 0));
    case (o)
      7'b0000011: begin
        exp_q.push_back(vec(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, im, 0));
        exp_q.push_back(vec(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, im, 0));
        exp_q.push_back(vec(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, im, 0));
      end
      7'b0100011: begin
        exp_q.push_back(vec(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, im, 0));
        exp_q.push_back(vec(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, im, 0));
      end
      7'b0110011: begin
        exp_q.push_back(vec(6, 0, 0, 0, 0, 0, 0, 2, 0, arith_ctl(o, f3, f7), im, 0));
        exp_q.push_back(vec(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, im, 0));
      end
      7'b0010011: begin
        exp_q.push_back(vec(7, 0, 0, 0, 0, 0, 0, 2, 1, arith_ctl(o, f3, f7), im, 0));
        exp_q.push_back(vec(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, im, 0));
      end
      7'b1100011: exp_q.push_back(vec(9, z, 0, 0, 0, 0, 0, 2, 0, 1, im, 0));
      7'b1101111: begin
        exp_q.push_back(vec(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, im, 0));
        exp_q.push_back(vec(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, im, 0));
      end
      default: ;
    endcase
  endtask

  // Drive one instruction and record the outputs of each of its cycles.
  task automatic capture(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int n);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      obs_q.push_back(obs);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    if (obs !== vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", obs, vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
    end
    vectors++;
    repeat (2) @(posedge clk);
    #1;
    if (obs !== vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_held: got %b expected %b", obs, vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
    end
    vectors++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_store();
    logic [6:0] ops[2];
    ops[0] = 7'b0000011;
    ops[1] = 7'b0100011;
    for (int k = 0; k < 2; k++) begin
      model_instr(ops[k], 3'd2, 1'b0, 1'b0);
      capture(ops[k], 3'd2, 1'b0, 1'b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL load_store op=%b cycle %0d: got %b expected %b", ops[k], i, obs_q[i],
                   exp_q[i]);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops[2];
    ops[0] = 7'b0110011;
    ops[1] = 7'b0010011;
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 8; f += 2) begin
        model_instr(ops[k], f[2:0], 1'b1, 1'b0);
        capture(ops[k], f[2:0], 1'b1, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
          if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL alu_ops op=%b f3=%0d cycle %0d: got %b expected %b", ops[k], f, i,
                     obs_q[i], exp_q[i]);
          end
          vectors++;
        end
      end
    end
  endtask

  task automatic test_branch_jump();
    for (int k = 0; k < 3; k++) begin
      logic [6:0] o;
      logic       z;
      o = (k == 2) ? 7'b1101111 : 7'b1100011;
      z = (k == 0);
      model_instr(o, 3'd0, 1'b0, z);
      capture(o, 3'd0, 1'b0, z, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL branch_jump op=%b zero=%0d cycle %0d: got %b expected %b", o, z, i,
                   obs_q[i], exp_q[i]);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_reset_mid_instr();
    op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (state !== 4'd3) begin
      miscompares++;
      $display("FAIL mid_reset_reach_memread: got state %0d expected 3", state);
    end
    vectors++;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (obs !== vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL mid_reset_low %0d: got %b expected %b", i, obs,
                 vec(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
      end
      vectors++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (obs !== vec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL mid_reset_release: got %b expected %b", obs,
               vec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0));
    end
    vectors++;
    @(posedge clk);
    #1;
    if (state !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_reset_decode: got state %0d expected 1", state);
    end
    vectors++;
    // Finish the restarted load so later tests begin in FETCH.
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    model_instr(7'b0000000, 3'd0, 1'b0, 1'b1);
    capture(7'b0000000, 3'd0, 1'b0, 1'b1, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal_decode cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
      vectors++;
    end
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      if (obs !== vec(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
        miscompares++;
        $display("FAIL illegal_trap cycle %0d: got %b expected %b", i, obs,
                 vec(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      vectors++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`else
    #1;
    if (obs !== vec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL illegal_nop: got %b expected %b", obs,
               vec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0));
    end
    vectors++;
`endif
  endtask

  task automatic test_random();
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7, z;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          o = 7'b0110011;
`else
          o = 7'($urandom_range(0, 127));
          while (is_legal(o)) o = 7'($urandom_range(0, 127));
`endif
        end
      endcase
      model_instr(o, f3, f7, z);
      capture(o, f3, f7, z, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random #%0d op=%b f3=%0d f7=%0d z=%0d cycle %0d: got %b expected %b",
                   n, o, f3, f7, z, i, obs_q[i], exp_q[i]);
        end
        vectors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_alu_ops();
    test_branch_jump();
    test_reset_mid_instr();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
